sr_pq_ctrl: RTL
===============

Name: sr_pq_ctrl

Overview:
Command-side initiator for the shift-register PQ stage array. It accepts a valid/ready command stream (enqueue, dequeue, replace, flush) and drives the broadcast enq/deq/replace/kvi controls into the stage chain. It also tracks occupancy, guards full/empty, and returns dequeued key-values through a one-entry valid/ready response register. It sits between the client datapath and the stage array; the array's stage-1 kv is its head input.

Parameters:
DEPTH, 8, number of stages in the attached array.
CW, $clog2(DEPTH+1), occupancy counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset; also resets the attached array
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  pq_op_t(2)  OP_ENQ / OP_DEQ / OP_REPL / OP_FLUSH
cmd_kv  in  kv_t  key-value for ENQ/REPL
rsp_valid  out  1  response kv held
rsp_ready  in  1  consumer takes response
rsp_kv  out  kv_t  dequeued key-value
pq_enq, pq_deq, pq_replace  out  1 each  broadcast stage controls; at most one high
pq_kvi  out  kv_t  broadcast input kv to stages
pq_head  in  kv_t  stage-1 kv (current minimum)
count  out  CW  current occupancy
full, empty  out  1  count==DEPTH, count==0
err_full, err_empty  out  1  one-cycle error pulses

Behaviour:
- States: S_RUN, S_FLUSH. Reset: S_RUN, count=0, rsp_valid=0, rsp_kv=KV_EMPTY, err_*=0, flush counter=0.
- cmd_ready = (state==S_RUN) && (!rsp_valid || rsp_ready). Accept = cmd_valid && cmd_ready.
- pq_* are combinational from accept, cmd_op, count and state. There are no registers on pq_*. Stages update at the same edge as the accept. pq_kvi = cmd_kv whenever pq_enq or pq_replace is high, else KV_EMPTY.
- OP_ENQ, !full: pq_enq=1, count+1. When full: no pq op, err_full pulses for the next cycle, count unchanged.
- OP_DEQ, !empty: pq_deq=1, rsp_kv<=pq_head (pre-shift value), rsp_valid<=1 next cycle, count-1. When empty: no pq op, err_empty pulses, no response.
- OP_REPL, !empty: pq_replace=1, rsp_kv<=pq_head, rsp_valid<=1, count unchanged. When empty: behaves as ENQ (pq_enq=1, count=1), no response, no error.
- OP_FLUSH, count>0: flush counter<=count, count<=0, go to S_FLUSH. In S_FLUSH, pq_deq=1 every cycle and the counter decrements; return to S_RUN after the cycle where the counter reaches 1. Latency is count cycles; cmd_ready=0 throughout; no responses. With count==0: no-op, stays S_RUN.
- Response register: cleared when rsp_valid && rsp_ready and no new load. A same-cycle load wins, so back-to-back DEQ sustains 1 result/cycle with rsp_ready=1. rsp_kv holds stable while rsp_valid && !rsp_ready.
- full/empty are combinational from count. count never exceeds DEPTH and never underflows.
- Reset mid-flush or mid-response: drops to reset values immediately, matching the simultaneously reset array.
- A held rsp_valid does not block flush completion. FLUSH is only accepted when the response slot can drain per the cmd_ready rule.

Decomposition:
- pq_pkg gains pq_op_t (2-bit enum OP_ENQ=0, OP_DEQ=1, OP_REPL=2, OP_FLUSH=3). kv_t and KV_EMPTY are reused from pq_pkg.
- No sub-module: one FSM plus counter plus response register in a single module. The bench instantiates it with an actual DEPTH-stage array as the golden partner.

Test Plan:
- DEPTH=4. ENQ keys 5,3,9 then DEQ×3 with rsp_ready=1 -> rsp_kv keys 3,5,9 on consecutive cycles; count 3→0; empty=1.
- ENQ 1,2,3,4 (full=1), ENQ 0 -> err_full pulse 1 cycle, count stays 4, pq_enq never asserted. DEQ -> key 1.
- Empty: DEQ -> err_empty, rsp_valid stays 0. REPL key 7 -> pq_enq=1, count=1, no rsp, no error.
- Contents {2,6,8}, REPL key 4 -> rsp key 2, count 3. Then DEQ×3 -> 4,6,8.
- rsp_ready=0 after a DEQ -> cmd_ready=0, rsp_kv stable for 5 cycles. Raise rsp_ready with a DEQ pending -> accepted the same cycle, new rsp next cycle.
- Contents 3 entries, FLUSH -> cmd_ready low exactly 3 cycles, pq_deq high 3 cycles, count=0, array all KV_EMPTY. Assert rst on the 2nd flush cycle -> S_RUN, count=0 the next cycle.

Source files
------------

// File: rtl/pq_pkg.sv
// =============================================================================
//  Module : pq_pkg
//  Shared types for the shift-register priority queue: key-value and op codes.
//  Rev    : 1.0
// =============================================================================
`default_nettype none

package pq_pkg;

  localparam int KW = 8;
  localparam int VW = 8;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] val;
  } kv_t;

  // An unoccupied stage carries the largest possible key so it sorts last.
  localparam kv_t KV_EMPTY = '{key: '1, val: '0};

  typedef enum logic [1:0] {
    OP_ENQ   = 2'd0,
    OP_DEQ   = 2'd1,
    OP_REPL  = 2'd2,
    OP_FLUSH = 2'd3
  } pq_op_t;

endpackage

`default_nettype wire

// File: rtl/sr_pq_ctrl.sv
// =============================================================================
//  Module : sr_pq_ctrl
//  Command-side initiator for the shift-register PQ stage array.
//  Rev    : 1.0
// =============================================================================
`default_nettype none

module sr_pq_ctrl
  import pq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  pq_op_t        cmd_op,
  input  kv_t           cmd_kv,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output kv_t           rsp_kv,
  output logic          pq_enq,
  output logic          pq_deq,
  output logic          pq_replace,
  output kv_t           pq_kvi,
  input  kv_t           pq_head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err_full,
  output logic          err_empty
);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nx;
  logic [CW-1:0] r_flush_cnt;
  logic [CW-1:0] w_flush_nx;
  logic          r_rsp_valid;
  kv_t           r_rsp_kv;
  logic          r_err_full;
  logic          r_err_empty;
  logic          w_accept;
  logic          w_load;
  logic          w_err_full_nx;
  logic          w_err_empty_nx;

  assign cmd_ready = (r_state == S_RUN) && (!r_rsp_valid || rsp_ready);
  assign w_accept  = cmd_valid && cmd_ready;
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rsp_valid = r_rsp_valid;
  assign rsp_kv    = r_rsp_kv;
  assign err_full  = r_err_full;
  assign err_empty = r_err_empty;
  assign pq_kvi    = (pq_enq || pq_replace) ? cmd_kv : KV_EMPTY;

  always_comb begin
    pq_enq         = 1'b0;
    pq_deq         = 1'b0;
    pq_replace     = 1'b0;
    w_state_nx     = r_state;
    w_count_nx     = r_count;
    w_flush_nx     = r_flush_cnt;
    w_load         = 1'b0;
    w_err_full_nx  = 1'b0;
    w_err_empty_nx = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          case (cmd_op)
            OP_ENQ: begin
              if (!full) begin
                pq_enq     = 1'b1;
                w_count_nx = r_count + CW'(1);
              end else begin
                w_err_full_nx = 1'b1;
              end
            end
            OP_DEQ: begin
              if (!empty) begin
                pq_deq     = 1'b1;
                w_load     = 1'b1;
                w_count_nx = r_count - CW'(1);
              end else begin
                w_err_empty_nx = 1'b1;
              end
            end
            OP_REPL: begin
              // Replace on an empty queue degenerates to a plain insert.
              if (!empty) begin
                pq_replace = 1'b1;
                w_load     = 1'b1;
              end else begin
                pq_enq     = 1'b1;
                w_count_nx = CW'(1);
              end
            end
            OP_FLUSH: begin
              if (!empty) begin
                w_flush_nx = r_count;
                w_count_nx = '0;
                w_state_nx = S_FLUSH;
              end
            end
            default: ;
          endcase
        end
      end
      S_FLUSH: begin
        // One shift per occupied stage pushes every entry off the end.
        pq_deq     = 1'b1;
        w_flush_nx = r_flush_cnt - CW'(1);
        if (r_flush_cnt == CW'(1)) begin
          w_state_nx = S_RUN;
        end
      end
      default: w_state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_count     <= '0;
      r_flush_cnt <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_kv    <= KV_EMPTY;
      r_err_full  <= 1'b0;
      r_err_empty <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_count     <= w_count_nx;
      r_flush_cnt <= w_flush_nx;
      r_err_full  <= w_err_full_nx;
      r_err_empty <= w_err_empty_nx;
      // pq_head is sampled before the stages shift on this same edge.
      if (w_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_kv    <= pq_head;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
